// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings and the control-word layout for the multi-cycle RV32I sequencer.
package multicycle_control_fsm_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 7;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational map from the current step (plus handshake/zero/reset) to the datapath control word.
module multicycle_ctrl_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_e i_state,
  input  logic   i_mem_ready,
  input  logic   i_zero,
  input  logic   i_reset,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    // Reset silences every strobe so an aborted instruction leaves no side effects.
    if (!i_reset) begin
      case (i_state)
        S_FETCH: begin
          o_ctrl.mem_read  = 1'b1;
          o_ctrl.alu_src_a = SRCA_PC;
          o_ctrl.alu_src_b = SRCB_FOUR;
          o_ctrl.alu_op    = ALUOP_ADD;
          o_ctrl.ir_write  = i_mem_ready;
          o_ctrl.pc_write  = i_mem_ready;
        end
        S_DECODE: begin
          o_ctrl.alu_src_a = SRCA_OLDPC;
          o_ctrl.alu_src_b = SRCB_IMM;
          o_ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMADR: begin
          o_ctrl.alu_src_a = SRCA_RS1;
          o_ctrl.alu_src_b = SRCB_IMM;
          o_ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMRD: begin
          o_ctrl.iord     = 1'b1;
          o_ctrl.mem_read = 1'b1;
        end
        S_MEMWB: begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          o_ctrl.iord      = 1'b1;
          o_ctrl.mem_write = 1'b1;
        end
        S_EXEC: begin
          o_ctrl.alu_src_a = SRCA_RS1;
          o_ctrl.alu_src_b = SRCB_RS2;
          o_ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          o_ctrl.reg_write = 1'b1;
        end
        S_BEQ: begin
          o_ctrl.alu_src_a = SRCA_RS1;
          o_ctrl.alu_src_b = SRCB_RS2;
          o_ctrl.alu_op    = ALUOP_SUB;
          o_ctrl.pc_source = 1'b1;
          o_ctrl.pc_write  = i_zero;
        end
        S_HALT: begin
          o_ctrl.halted = 1'b1;
        end
        default: o_ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: state register, opcode-driven next-state logic and retire counter.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 PCSource,
  output logic                 halted,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_e               r_state;
  logic [CNT_WIDTH-1:0] r_count;
  ctrl_t                w_ctrl;
  logic                 w_retire;

  // An instruction retires on the edge that leaves its final step.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                    ((r_state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      if (w_retire) r_count <= r_count + CNT_WIDTH'(1);
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:          r_state <= S_EXEC;
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_BRANCH:         r_state <= S_BEQ;
            default:           r_state <= S_HALT;
          endcase
        end
        S_MEMADR: begin
          case (opcode)
            OP_LOAD:  r_state <= S_MEMRD;
            OP_STORE: r_state <= S_MEMWR;
            default:  r_state <= S_HALT;
          endcase
        end
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BEQ:    r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_HALT;
      endcase
    end
  end

  multicycle_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_zero      (zero),
    .i_reset     (reset),
    .o_ctrl      (w_ctrl)
  );

  assign PCWrite     = w_ctrl.pc_write;
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign halted      = w_ctrl.halted;
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequencing controller for the multi-cycle variant of the RV32I core. It replaces the single-cycle combinational control unit, and the core then shares one unified instruction/data memory port. It drives every datapath enable and mux select through FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps, stalls on a memory-ready handshake, traps unsupported opcodes into a halt state, and counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter instr_count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  IR[6:0] from instruction register
zero  input  1  ALU zero flag (A == B)
mem_ready  input  1  memory completes current read/write this cycle
PCWrite  output  1  PC register load enable
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register (and OldPC) load enable
MemtoReg  output  1  writeback select: 0 = ALUOut, 1 = memory data register
RegWrite  output  1  register-file write enable
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1 data
ALUSrcB  output  2  00 = rs2 data, 01 = constant 4, 10 = ImmExt
ALUOp  output  2  00 = add, 01 = subtract (branch), 10 = funct-decoded (to ALU_Control)
PCSource  output  1  PC next select: 0 = ALU result, 1 = ALUOut
halted  output  1  high while in HALT
state  output  4  current state encoding (debug)
instr_count  output  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH

Behaviour:
- Opcodes: R-type 0110011, LW 0000011, SW 0100011, BEQ 1100011. Any other opcode is illegal.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, HALT=9.
- Reset behaviour (asynchronous):
  - state=FETCH, instr_count=0.
  - While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and MemRead are forced 0 and halted=0.
  - Reset mid-operation aborts the instruction with no further strobes.
- Unlisted outputs are 0 in each state; selects not listed are don't-care but must drive 0.
- FETCH:
  - Outputs: IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite = PCWrite = mem_ready (Mealy).
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00 (ALUOut <= branch target).
  - Next state: R→EXEC, LW/SW→MEMADR, BEQ→BEQ, illegal→HALT.
- MEMADR: ALUSrcA=10, ALUSrcB=10, ALUOp=00. Next: LW→MEMRD, SW→MEMWR.
- MEMRD: IorD=1, MemRead=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1. Goes to FETCH; instruction retires.
- MEMWR:
  - IorD=1, MemWrite=1, held stable until mem_ready=1.
  - On mem_ready=1: goes to FETCH; instruction retires.
- EXEC: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0. Goes to FETCH; instruction retires.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=zero.
  - Goes to FETCH; instruction retires whether or not the branch is taken.
- HALT: all strobes 0, halted=1. Remains in HALT until reset.
- Retire: instr_count increments by 1 on the clock edge that leaves the retiring state. Wraps from all-ones to 0.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Latency with mem_ready tied high: R=4 cycles, LW=5, SW=4, BEQ=3. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly 1 cycle.
- The opcode input is sampled only in DECODE and MEMADR; IR is stable after FETCH.

Decomposition:
- Shared package holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH)
  - ALUOp encodings
  - ALUSrcA/ALUSrcB encodings
- One natural sub-module, multicycle_ctrl_decode: a purely combinational map from {state, mem_ready, zero, reset} to the control word.
- The top holds the state register, next-state logic and retire counter.

Test Plan:
1. Reset, then opcode=0110011 with mem_ready=1: states 0,1,6,7,0; RegWrite=1 only in ALUWB; instr_count=1 after cycle 4.
2. LW (0000011), mem_ready low for 2 cycles in MEMRD: MemRead/IorD=1 held for 3 cycles; total 7 cycles; MemtoReg=1 with RegWrite in MEMWB.
3. SW (0100011), mem_ready=1: MemWrite=1 exactly 1 cycle in state 5; RegWrite never asserts; 4 cycles; instr_count +1.
4. BEQ with zero=1, then BEQ with zero=0: PCWrite=1 and PCSource=1 in BEQ only for the first; both take 3 cycles; instr_count +2.
5. Opcode 0010011 (illegal): DECODE→HALT; halted=1 with all strobes 0 for 20 cycles; instr_count unchanged; reset returns to FETCH with count=0.
6. Assert reset during MEMWR with mem_ready=0: MemWrite drops in the same cycle (asynchronously); state=0 and instr_count=0 after reset deasserts.
